// File: rtl/glitch_filter.sv
// Multi-channel input conditioner: two-flop synchroniser, N-cycle stability filter,
// edge/glitch pulses and a saturating rejected-glitch counter.
module glitch_filter #(
   parameter int unsigned W  = 4,
   parameter int unsigned N  = 3,
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic          clear,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [W-1:0]  rise,
   output logic [W-1:0]  fall,
   output logic [W-1:0]  glitch,
   output logic [CW-1:0] gcount
);

   localparam int unsigned CNTW = $clog2(N + 1);
   localparam int unsigned PW   = $clog2(W + 1);
   localparam int unsigned SW   = ((CW > PW) ? CW : PW) + 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);
   localparam logic [SW-1:0]   GMAX     = {{(SW - CW){1'b0}}, {CW{1'b1}}};

   logic [W-1:0]            sync1_q, sync1_d;
   logic [W-1:0]            s_q, s_d;
   logic [W-1:0][CNTW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]            dout_q, dout_d;
   logic [W-1:0]            rise_q, rise_d;
   logic [W-1:0]            fall_q, fall_d;
   logic [W-1:0]            glitch_q, glitch_d;
   logic [CW-1:0]           gcount_q, gcount_d;
   logic [SW-1:0]           pop;
   logic [SW-1:0]           gsum;

   // Per-channel stability filter; en=0 freezes count and output.
   always_comb begin
      sync1_d  = din;
      s_d      = sync1_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      rise_d   = '0;
      fall_d   = '0;
      glitch_d = '0;
      if (en) begin
         for (int unsigned i = 0; i < W; i++) begin
            if (s_q[i] != dout_q[i]) begin
               if (cnt_q[i] == CNT_LAST) begin
                  dout_d[i] = s_q[i];
                  cnt_d[i]  = '0;
                  rise_d[i] = s_q[i];
                  fall_d[i] = ~s_q[i];
               end else begin
                  cnt_d[i] = cnt_q[i] + CNTW'(1);
               end
            end else if (cnt_q[i] != '0) begin
               cnt_d[i]    = '0;
               glitch_d[i] = 1'b1;
            end
         end
      end
   end

   // Saturating glitch total; clear wins over glitches reported this cycle.
   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < W; i++) begin
         pop = pop + SW'(glitch_q[i]);
      end
      gsum     = SW'(gcount_q) + pop;
      gcount_d = gcount_q;
      if (clear) begin
         gcount_d = '0;
      end else if (gsum > GMAX) begin
         gcount_d = {CW{1'b1}};
      end else begin
         gcount_d = gsum[CW-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= '0;
         s_q      <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         glitch_q <= '0;
         gcount_q <= '0;
      end else begin
         sync1_q  <= sync1_d;
         s_q      <= s_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
         gcount_q <= gcount_d;
      end
   end

   assign dout   = dout_q;
   assign rise   = rise_q;
   assign fall   = fall_q;
   assign glitch = glitch_q;
   assign gcount = gcount_q;

endmodule

// File: tb/tb_glitch_filter.sv
// Directed bench for glitch_filter: W=4, N=3 with an 8-bit and a 2-bit glitch counter.
module tb_glitch_filter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       en = 1'b1;
   logic       clear = 1'b0;
   logic [3:0] din = 4'h0;
   logic [3:0] dout, rise, fall, glitch;
   logic [7:0] gcount;
   logic [3:0] dout_s, rise_s, fall_s, glitch_s;
   logic [1:0] gcount_s;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] din;
      logic       en;
      logic       clr;
      logic [3:0] dout;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] glitch;
      logic [7:0] gc;
      logic [1:0] gc2;
   } vec_t;

   vec_t tbl[$];

   glitch_filter #(.W(4), .N(3), .CW(8)) u_dut (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .din(din),
      .dout(dout), .rise(rise), .fall(fall), .glitch(glitch), .gcount(gcount)
   );

   glitch_filter #(.W(4), .N(3), .CW(2)) u_sat (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .din(din),
      .dout(dout_s), .rise(rise_s), .fall(fall_s), .glitch(glitch_s), .gcount(gcount_s)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] d, input logic [3:0] o, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] g, input logic [7:0] gc,
                      input logic [1:0] gc2);
      vec_t v;
      v.din = d; v.en = 1'b1; v.clr = 1'b0;
      v.dout = o; v.rise = r; v.fall = f; v.glitch = g; v.gc = gc; v.gc2 = gc2;
      tbl.push_back(v);
   endtask

   task automatic pulse(input logic [3:0] d);
      din = d;
      step();
      din = 4'h0;
      repeat (5) step();
   endtask

   initial begin
      // clean step on ch0, rise at the 5th edge, fall 5 edges after stepping back
      repeat (4) add(4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0);
      add(4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'd0, 2'd0);
      add(4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0);
      repeat (4) add(4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0);
      add(4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 8'd0, 2'd0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0);
      // 2-cycle pulse on ch1 is rejected
      repeat (2) add(4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0);
      repeat (2) add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd0, 2'd0);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 8'd0, 2'd0);
      repeat (2) add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1);
      // 3-cycle pulse on ch1 passes, dout high for 3 cycles
      repeat (3) add(4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1);
      add(4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 8'd1, 2'd1);
      repeat (2) add(4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1);
      add(4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 8'd1, 2'd1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1);
      // simultaneous 1-cycle glitches on channels 0, 2, 3
      add(4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1);
      repeat (2) add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd1, 2'd1);
      add(4'h0, 4'h0, 4'h0, 4'h0, 4'hD, 8'd1, 2'd1);
      repeat (2) add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd4, 2'd3);

      #2 reset_n = 1'b0;
      repeat (2) step();
      chk("reset_state", 64'({dout, rise, fall, glitch, gcount, dout_s, gcount_s}), 64'h0);
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         din = tbl[i].din; en = tbl[i].en; clear = tbl[i].clr;
         step();
         chk($sformatf("row%0d", i), 64'({dout, rise, fall, glitch, gcount, gcount_s}),
             64'({tbl[i].dout, tbl[i].rise, tbl[i].fall, tbl[i].glitch, tbl[i].gc, tbl[i].gc2}));
      end

      // saturation: clear, then six separate glitches
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_idle", 64'({gcount, gcount_s}), 64'h0);
      for (int k = 1; k <= 6; k++) begin
         pulse(4'h1);
         chk($sformatf("sat_gc_%0d", k), 64'({gcount, gcount_s}),
             64'({8'(k), (k > 3) ? 2'd3 : 2'(k)}));
      end

      // clear coinciding with a glitch pulse
      din = 4'h1;
      step();
      din = 4'h0;
      repeat (3) step();
      chk("glitch_before_clear", 64'(glitch), 64'h1);
      clear = 1'b1;
      step();
      chk("clear_with_glitch", 64'({gcount, gcount_s}), 64'h0);
      clear = 1'b0;
      step();
      chk("clear_after", 64'({gcount, gcount_s}), 64'h0);

      // enable: freeze with cnt[0]=1 for two cycles, then finish after two enabled edges
      din = 4'h1;
      repeat (3) step();
      en = 1'b0;
      step();
      chk("en_hold_1", 64'({dout, rise, fall, glitch}), 64'h0);
      step();
      chk("en_hold_2", 64'({dout, rise, fall, glitch}), 64'h0);
      en = 1'b1;
      step();
      chk("en_resume_1", 64'({dout, rise}), 64'h0);
      step();
      chk("en_resume_2", 64'({dout, rise, glitch}), 64'({4'h1, 4'h1, 4'h0}));
      din = 4'h0;
      repeat (6) step();
      chk("en_return", 64'({dout, gcount}), 64'h0);

      // asynchronous reset with all channels high, then recovery
      pulse(4'h2);
      din = 4'hF;
      repeat (6) step();
      chk("pre_reset", 64'({dout, gcount}), 64'({4'hF, 8'd1}));
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset", 64'({dout, rise, fall, glitch, gcount, dout_s, gcount_s}), 64'h0);
      #1 reset_n = 1'b1;
      repeat (4) step();
      chk("post_reset_4", 64'({dout, rise}), 64'h0);
      step();
      chk("post_reset_5", 64'({dout, rise}), 64'hFF);
      step();
      chk("post_reset_6", 64'({dout, rise, fall}), 64'({4'hF, 4'h0, 4'h0}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
